axis_frame_source: RTL and testbench
====================================

Name: axis_frame_source

Overview:
- Synthesizable AXI4-Stream master that feeds frames of hyperspectral samples into a kernel's in_stream port.
- Host side pushes words into an internal FIFO; a start pulse emits num_frames frames of frame_len beats each, with TLAST on the final beat of every frame.
- Optional pseudo-random TVALID bubbles stress the kernel's input-blocking paths.
- Exports an active-low block flag in the same form as the kernel's *_TDATA_blk_n signals, so the deadlock monitors can observe it.

Parameters:
DATA_W, 32, TDATA width in bits
DEPTH, 16, FIFO depth in words; must be a power of two, minimum 2
LEN_W, 16, width of frame_len, num_frames and the status counters
LFSR_SEED, 16'hACE1, reset value of the 16-bit stall LFSR (must be non-zero)

Ports:
ap_clk  in  1  clock; all logic is on the rising edge
ap_rst  in  1  asynchronous, active-high reset
wr_en  in  1  push wr_data into the FIFO
wr_data  in  DATA_W  sample word
wr_full  out  1  FIFO full; a push while full is dropped and counted in ovf_cnt
start  in  1  single-cycle pulse; accepted only in IDLE
frame_len  in  LEN_W  beats per frame; sampled at start; 0 is treated as 1
num_frames  in  LEN_W  frames per run; sampled at start; 0 means no run
stall_thr  in  8  bubble threshold, used only when AXIS_SRC_STALL_EN is defined
m_axis_TDATA  out  DATA_W  stream data
m_axis_TVALID  out  1  stream valid
m_axis_TREADY  in  1  stream ready from the kernel
m_axis_TLAST  out  1  high on the last beat of each frame
src_blk_n  out  1  0 when TVALID=1 and TREADY=0
busy  out  1  high in RUN and GAP
done  out  1  single-cycle pulse when the last beat of the run handshakes
ovf_cnt  out  LEN_W  dropped pushes; saturates at all-ones
stall_cnt  out  LEN_W  cycles with TVALID=1 and TREADY=0; saturates at all-ones

Behaviour:
- Reset (asynchronous, ap_rst=1): state=IDLE; the following are all 0: TVALID, TLAST, TDATA, busy, done, both counters, FIFO pointers. wr_full=0. src_blk_n=1. LFSR=LFSR_SEED. Reset during a run aborts it immediately and discards FIFO contents; no done pulse is issued.
- FIFO: occupancy is tracked with a DEPTH+1 counter (log2(DEPTH)+1 bits).
  - Push while full is dropped and ovf_cnt increments.
  - Pop happens only on a beat handshake (TVALID & TREADY).
  - Simultaneous push and pop when full is legal: the pop frees the slot and the push is accepted.
  - Words written during IDLE are retained for the next run.
- Beat handshake: a beat transfers on a rising edge where TVALID=1 and TREADY=1.
- FSM states: IDLE, RUN, GAP.
  - IDLE -> RUN on start with num_frames != 0. Sample frame_len and num_frames; clear beat_idx and frame_idx. start with num_frames=0 gives a done pulse the next cycle and the FSM stays in IDLE.
  - RUN: TVALID is asserted the cycle after the FIFO becomes non-empty (registered output, one cycle of latency from push to valid when the FIFO was empty). TDATA is the FIFO head. TLAST = (beat_idx == frame_len-1).
  - RUN, on each handshake: beat_idx increments. On the TLAST beat, beat_idx returns to 0 and frame_idx increments. On the TLAST beat of the last frame: go to IDLE, done=1 for one cycle, TVALID=0 on the next cycle.
  - RUN -> GAP: only from a cycle with TVALID=0 (bubble decision). GAP lasts exactly one cycle, with TVALID=0, then returns to RUN.
- AXIS rules:
  - Once TVALID=1, it stays high, and TDATA/TLAST stay stable, until the handshake.
  - Bubbles are inserted only between beats, never while a beat is pending.
  - TREADY is never a combinational input to TVALID.
- FIFO empty in RUN: TVALID=0 (underflow stall); the FSM stays in RUN and nothing is counted.
- stall_cnt increments on every cycle with TVALID & ~TREADY.
- src_blk_n = ~(TVALID & ~TREADY), combinational.

Optional Feature:
- Macro: AXIS_SRC_STALL_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16, 14, 13, 11) advances every cycle while not in reset. In RUN, when no beat is pending and LFSR[7:0] < stall_thr, the next cycle is GAP. stall_thr=0 means no bubbles; stall_thr=255 gives bubbles on about 99.6% of eligible cycles.
- Undefined: no LFSR and no GAP state. stall_thr is ignored, and TVALID is asserted whenever the FIFO is non-empty in RUN.

Decomposition:
- Package axis_src_pkg: state enum (IDLE, RUN, GAP), LFSR tap mask constant, default LFSR_SEED.
- One sub-module, axis_src_fifo: synchronous FIFO with parameters DATA_W and DEPTH, ports push/pop/full/empty/head. Single clock, asynchronous active-high reset.

Test Plan:
1. Push 8 words 0..7, frame_len=4, num_frames=2, TREADY tied 1, macro off -> 8 consecutive beats; TLAST on beats 3 and 7; done pulse on the cycle of beat 7; stall_cnt=0.
2. Same stimulus, TREADY low for 5 cycles while beat 2 is pending -> TDATA=2 and TLAST=0 held stable; src_blk_n=0 for those 5 cycles; stall_cnt=5.
3. Push 17 words with DEPTH=16 and no run -> wr_full=1; ovf_cnt=1; a later run outputs 0..15 only.
4. frame_len=0, num_frames=3, 3 words pushed -> every beat has TLAST=1; done after the 3rd beat.
5. Assert ap_rst mid-frame after 2 of 4 beats -> all outputs at reset values asynchronously; no done; after release, start with 4 fresh words transfers from word 0.
6. Macro on, stall_thr=128, 64 beats, TREADY=1 -> all 64 beats delivered in order with correct TLAST; GAP cycles are present, and bubbles appear only between beats.

Source files
------------

// File: rtl/axis_src_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_src_pkg
// Description : Shared types and constants for the AXI4-Stream frame source:
//               FSM state encoding, stall-LFSR tap mask and default seed.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_src_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAP_MASK)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_frame_source_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_source_if
// Description : AXI4-Stream bundle (TDATA/TVALID/TREADY/TLAST) with master
//               and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_frame_source_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] TDATA;
  logic              TVALID;
  logic              TREADY;
  logic              TLAST;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface
`default_nettype wire

// File: rtl/axis_src_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_src_fifo
// Description : Single-clock FIFO, power-of-two depth, occupancy counter of
//               log2(DEPTH)+1 bits. A push while full is accepted only when
//               a pop frees a slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_src_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              push,
  input  wire logic [DATA_W-1:0] push_data,
  input  wire logic              pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [DATA_W-1:0]      head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only observable behind the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule
`default_nettype wire

// File: rtl/axis_frame_source.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_source
// Description : AXI4-Stream master emitting num_frames frames of frame_len
//               beats from an internal FIFO, with TLAST per frame, an
//               active-low block flag and saturating status counters.
//               Macro AXIS_SRC_STALL_EN enables LFSR-driven TVALID bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_source
  import axis_src_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 16,
  parameter int          LEN_W     = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  wire logic              ap_clk,
  input  wire logic              ap_rst,
  input  wire logic              wr_en,
  input  wire logic [DATA_W-1:0] wr_data,
  output logic                   wr_full,
  input  wire logic              start,
  input  wire logic [LEN_W-1:0]  frame_len,
  input  wire logic [LEN_W-1:0]  num_frames,
  input  wire logic [7:0]        stall_thr,
  axis_frame_source_if.master    m_axis,
  output logic                   src_blk_n,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_W-1:0]       ovf_cnt,
  output logic [LEN_W-1:0]       stall_cnt
);
  state_t             state_q, state_d;
  logic               tvalid_q, tvalid_d;
  logic [LEN_W-1:0]   len_m1_q, len_m1_d;
  logic [LEN_W-1:0]   nfr_q, nfr_d;
  logic [LEN_W-1:0]   beat_idx_q, beat_idx_d;
  logic [LEN_W-1:0]   frame_idx_q, frame_idx_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   ovf_q, ovf_d;
  logic [LEN_W-1:0]   stall_q, stall_d;

  logic               fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [DATA_W-1:0]  fifo_head;
  logic               hs, last_beat, last_frame, run_end, avail, blocked, bubble;

  axis_src_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (hs),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign hs         = tvalid_q & m_axis.TREADY;
  assign blocked    = tvalid_q & ~m_axis.TREADY;
  assign last_beat  = (beat_idx_q == len_m1_q);
  assign last_frame = (frame_idx_q == nfr_q - 1'b1);
  assign run_end    = hs & last_beat & last_frame;
  // Ignores a push in the same cycle, giving one cycle of push-to-valid latency
  assign avail      = hs ? (fifo_count > 1) : ~fifo_empty;

`ifdef AXIS_SRC_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);
  assign bubble = (lfsr_q[7:0] < stall_thr);

  // Free-running stall LFSR
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{stall_thr, LFSR_SEED};
  assign bubble     = 1'b0;
`endif

  // Next-state, beat/frame tracking and registered TVALID
  always_comb begin
    state_d     = state_q;
    tvalid_d    = 1'b0;
    len_m1_d    = len_m1_q;
    nfr_d       = nfr_q;
    beat_idx_d  = beat_idx_q;
    frame_idx_d = frame_idx_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_frames != '0) begin
            state_d     = RUN;
            len_m1_d    = (frame_len == '0) ? '0 : frame_len - 1'b1;
            nfr_d       = num_frames;
            beat_idx_d  = '0;
            frame_idx_d = '0;
            tvalid_d    = ~fifo_empty;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs) begin
          if (last_beat) begin
            beat_idx_d = '0;
            if (last_frame) begin
              state_d  = IDLE;
              tvalid_d = 1'b0;
            end else begin
              frame_idx_d = frame_idx_q + 1'b1;
              tvalid_d    = avail;
            end
          end else begin
            beat_idx_d = beat_idx_q + 1'b1;
            tvalid_d   = avail;
          end
        end else if (tvalid_q) begin
          tvalid_d = 1'b1;               // beat pending: hold until accepted
        end else if (bubble) begin
          state_d  = GAP;                // bubble only when nothing is pending
          tvalid_d = 1'b0;
        end else begin
          tvalid_d = avail;
        end
      end
      GAP: begin
        state_d  = RUN;
        tvalid_d = ~fifo_empty;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating status counters
  always_comb begin
    ovf_d   = ovf_q;
    stall_d = stall_q;
    if (wr_en && fifo_full && !hs && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
    if (blocked && (stall_q != '1))                 stall_d = stall_q + 1'b1;
  end

  // State and status registers
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      tvalid_q    <= 1'b0;
      len_m1_q    <= '0;
      nfr_q       <= '0;
      beat_idx_q  <= '0;
      frame_idx_q <= '0;
      done_q      <= 1'b0;
      ovf_q       <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      len_m1_q    <= len_m1_d;
      nfr_q       <= nfr_d;
      beat_idx_q  <= beat_idx_d;
      frame_idx_q <= frame_idx_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      stall_q     <= stall_d;
    end
  end

  assign m_axis.TVALID = tvalid_q;
  assign m_axis.TDATA  = tvalid_q ? fifo_head : '0;
  assign m_axis.TLAST  = tvalid_q & last_beat;
  assign src_blk_n     = ~blocked;
  assign busy          = (state_q != IDLE);
  assign done          = done_q | run_end;
  assign wr_full       = fifo_full;
  assign ovf_cnt       = ovf_q;
  assign stall_cnt     = stall_q;
endmodule
`default_nettype wire

// File: tb/tb_axis_frame_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_source
// Description : Scoreboard bench for axis_frame_source. Stimulus queues the
//               expected beats; a negedge monitor pops and compares on every
//               handshake and checks AXIS hold rules and the block flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_source;
  import axis_src_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LEN_W  = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              fin;
  } exp_t;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_full;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  frame_len = '0;
  logic [LEN_W-1:0]  num_frames = '0;
  logic [7:0]        stall_thr = 8'd0;
  logic              src_blk_n, busy, done;
  logic [LEN_W-1:0]  ovf_cnt, stall_cnt;

  axis_frame_source_if #(.DATA_W(DATA_W)) m_axis ();

  axis_frame_source #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_full    (wr_full),
    .start      (start),
    .frame_len  (frame_len),
    .num_frames (num_frames),
    .stall_thr  (stall_thr),
    .m_axis     (m_axis),
    .src_blk_n  (src_blk_n),
    .busy       (busy),
    .done       (done),
    .ovf_cnt    (ovf_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_seen = 0;
  int   exp_done = 0;
  int   hs_count = 0;
  int   first_hs_cyc = 0;
  int   last_hs_cyc = 0;
  int   blk_cycles = 0;
  int   gap_cycles = 0;
  exp_t exp_q[$];

  logic              prev_pend = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge ap_clk) cyc++;

  // Monitor: compares every handshake against the scoreboard queue
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      prev_pend = 1'b0;
    end else begin
      exp_t e;
      if (prev_pend) begin
        chk("hold_valid", m_axis.TVALID, 1'b1);
        chk("hold_data", m_axis.TDATA, prev_data);
        chk("hold_last", m_axis.TLAST, prev_last);
      end
      chk("blk_n", src_blk_n, !(m_axis.TVALID && !m_axis.TREADY));
      if (!src_blk_n) blk_cycles++;
      if (done) done_seen++;
`ifdef AXIS_SRC_STALL_EN
      if (dut.state_q == GAP) gap_cycles++;
`endif
      if (m_axis.TVALID && m_axis.TREADY) begin
        hs_count++;
        if (hs_count == 1) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h, required no beat", m_axis.TDATA);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_axis.TDATA, e.data);
          chk("beat_last", m_axis.TLAST, e.last);
          chk("beat_done", done, e.fin);
        end
      end
      prev_pend = m_axis.TVALID && !m_axis.TREADY;
      prev_data = m_axis.TDATA;
      prev_last = m_axis.TLAST;
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic queue_frames(input logic [DATA_W-1:0] base, input int fl, input int nf);
    int eff;
    int idx;
    exp_t e;
    eff = (fl == 0) ? 1 : fl;
    idx = 0;
    for (int f = 0; f < nf; f++) begin
      for (int b = 0; b < eff; b++) begin
        e.data = base + DATA_W'(idx);
        e.last = (b == eff - 1);
        e.fin  = (f == nf - 1) && (b == eff - 1);
        exp_q.push_back(e);
        idx++;
      end
    end
    if (nf != 0) exp_done++;
  endtask

  task automatic do_start(input int fl, input int nf);
    start      = 1'b1;
    frame_len  = LEN_W'(fl);
    num_frames = LEN_W'(nf);
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      tick();
      c++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", nm, budget);
    end
    tick();
    tick();
    chk({nm, "_beats_left"}, exp_q.size(), 0);
    chk({nm, "_done_cnt"}, done_seen, exp_done);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_stall;
    m_axis.TREADY = 1'b0;

    // Reset state
    #12;
    chk("rst_tvalid", m_axis.TVALID, 0);
    chk("rst_tlast", m_axis.TLAST, 0);
    chk("rst_tdata", m_axis.TDATA, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_full", wr_full, 0);
    chk("rst_blk_n", src_blk_n, 1);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    tick();

    // 1: two frames of four, always ready
    m_axis.TREADY = 1'b1;
    for (int i = 0; i < 8; i++) push(DATA_W'(i));
    hs_count = 0;
    queue_frames(0, 4, 2);
    do_start(4, 2);
    chk("t1_busy", busy, 1);
    wait_idle("t1", 200);
    chk("t1_span", last_hs_cyc - first_hs_cyc, 7);
    chk("t1_stall", stall_cnt, 0);

    // 2: back-pressure for five cycles on beat 2
    for (int i = 0; i < 8; i++) push(DATA_W'(i));
    blk_cycles = 0;
    queue_frames(0, 4, 2);
    do_start(4, 2);
    tick();
    tick();
    m_axis.TREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("t2_data", m_axis.TDATA, 2);
      chk("t2_last", m_axis.TLAST, 0);
      chk("t2_blk_n", src_blk_n, 0);
      tick();
    end
    m_axis.TREADY = 1'b1;
    wait_idle("t2", 200);
    chk("t2_blk_cycles", blk_cycles, 5);
    chk("t2_stall", stall_cnt, 5);

    // 3: overflow by one, then drain
    for (int i = 0; i < 17; i++) push(32'h100 + DATA_W'(i));
    chk("t3_full", wr_full, 1);
    chk("t3_ovf", ovf_cnt, 1);
    queue_frames(32'h100, 16, 1);
    do_start(16, 1);
    wait_idle("t3", 200);
    chk("t3_empty_full", wr_full, 0);

    // 4: frame_len 0 behaves as 1; then a zero-frame start
    for (int i = 0; i < 3; i++) push(32'h40 + DATA_W'(i));
    queue_frames(32'h40, 0, 3);
    do_start(0, 3);
    wait_idle("t4", 200);
    do_start(4, 0);
    exp_done++;
    @(negedge ap_clk);
    chk("t4_zero_done", done, 1);
    chk("t4_zero_busy", busy, 0);
    tick();
    tick();
    chk("t4_done_cnt", done_seen, exp_done);

    // 5: asynchronous reset mid-frame
    for (int i = 0; i < 4; i++) push(32'h200 + DATA_W'(i));
    queue_frames(32'h200, 4, 1);
    exp_done--;
    do_start(4, 1);
    tick();
    tick();
    ap_rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t5_tvalid", m_axis.TVALID, 0);
    chk("t5_tlast", m_axis.TLAST, 0);
    chk("t5_tdata", m_axis.TDATA, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_blk_n", src_blk_n, 1);
    chk("t5_stall", stall_cnt, 0);
    chk("t5_ovf", ovf_cnt, 0);
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    tick();
    chk("t5_done_cnt", done_seen, exp_done);
    for (int i = 0; i < 4; i++) push(32'h300 + DATA_W'(i));
    queue_frames(32'h300, 4, 1);
    do_start(4, 1);
    wait_idle("t5", 200);

    // 6: 64 beats with the FIFO refilled during the run
`ifdef AXIS_SRC_STALL_EN
    stall_thr = 8'd128;
`endif
    base_stall = int'(stall_cnt);
    gap_cycles = 0;
    for (int i = 0; i < 16; i++) push(32'h1000 + DATA_W'(i));
    queue_frames(32'h1000, 8, 8);
    do_start(8, 8);
    for (int i = 16; i < 64; i++) begin
      push(32'h1000 + DATA_W'(i));
      tick();
    end
    wait_idle("t6", 2000);
    chk("t6_stall", stall_cnt, base_stall);
`ifdef AXIS_SRC_STALL_EN
    chk("t6_gap_present", gap_cycles > 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
